// File: rtl/ps2_receptor_if.sv
// PS/2 receiver bus: raw keyboard lines in, scan code and frame status out.
interface ps2_receptor_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       finish_ps2;
    logic       erro_quadro;

    // Keyboard/stimulus side: drives the raw lines, observes the results.
    modport master (
        output ps2_clk,
        output ps2_data,
        input  scancode,
        input  finish_ps2,
        input  erro_quadro
    );

    // Receiver side.
    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output scancode,
        output finish_ps2,
        output erro_quadro
    );
endinterface

// File: rtl/ps2_receptor.sv
// PS/2 keyboard frame receiver.
// Synchronises and glitch-filters the keyboard lines, deserialises 11-bit frames
// (start, 8 data bits LSB first, odd parity, stop), and publishes each good byte
// on scancode followed one clock later by a toggle of finish_ps2. Bad frames and
// stalled frames produce a single-cycle erro_quadro pulse.
module ps2_receptor #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    ps2_receptor_if.slave ps2
);

    localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned ToW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);
    localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StOcioso,
        StDados,
        StParidade,
        StParada
    } state_e;

    // Input synchronisers, idle-high so reset does not look like a falling edge.
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   w_clk_synced;
    logic                   w_data_synced;

    // Glitch filter and edge detect.
    logic [FiltW-1:0]       r_filt_cnt;
    logic                   r_clk_filt;
    logic                   r_clk_filt_d;
    logic                   w_queda;

    // Frame FSM.
    state_e                 r_state;
    state_e                 w_state_next;

    // FSM strobes.
    logic                   w_start;
    logic                   w_shift_en;
    logic                   w_par_en;
    logic                   w_frame_ok;
    logic                   w_frame_err;
    logic                   w_timeout;

    // Datapath.
    logic [7:0]             r_shift;
    logic [2:0]             r_bit_cnt;
    logic                   r_parity_ok;
    logic [ToW-1:0]         r_to_cnt;

    // Output registers.
    logic [7:0]             r_scancode;
    logic                   r_finish;
    logic                   r_erro;
    logic                   r_valid_d;

    assign w_clk_synced  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_synced = r_data_sync[SYNC_STAGES-1];

    // Shift the asynchronous keyboard lines through the synchroniser chains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2.ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2.ps2_data};
        end
    end

    // Accept a new ps2_clk level only after it has persisted FILTER_LEN cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_cnt   <= '0;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
        end else begin
            r_clk_filt_d <= r_clk_filt;
            if (w_clk_synced == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FiltLast) begin
                r_clk_filt <= w_clk_synced;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FiltW'(1);
            end
        end
    end

    // One-cycle strobe on each filtered falling edge.
    assign w_queda = r_clk_filt_d & ~r_clk_filt;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StOcioso;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: advance on queda; a timeout only matters without a queda.
    always_comb begin
        w_state_next = r_state;
        if (w_queda) begin
            case (r_state)
                StOcioso:   if (!w_data_synced) w_state_next = StDados;
                StDados:    if (r_bit_cnt == 3'd7) w_state_next = StParidade;
                StParidade: w_state_next = StParada;
                StParada:   w_state_next = StOcioso;
                default:    w_state_next = StOcioso;
            endcase
        end else if (w_timeout) begin
            w_state_next = StOcioso;
        end
    end

    // FSM outputs: per-state strobes for the datapath and the result registers.
    always_comb begin
        w_start     = 1'b0;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_frame_ok  = 1'b0;
        w_frame_err = 1'b0;
        w_timeout   = (r_state != StOcioso) && !w_queda && (r_to_cnt == ToLast);
        if (w_queda) begin
            case (r_state)
                StOcioso:   w_start    = ~w_data_synced;
                StDados:    w_shift_en = 1'b1;
                StParidade: w_par_en   = 1'b1;
                StParada: begin
                    w_frame_ok  = w_data_synced & r_parity_ok;
                    w_frame_err = ~(w_data_synced & r_parity_ok);
                end
                default: ;
            endcase
        end
    end

    // Deserialise data bits LSB first and latch the parity verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_parity_ok <= 1'b0;
        end else if (w_timeout) begin
            // Partial byte is thrown away.
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_parity_ok <= 1'b0;
        end else begin
            if (w_start) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_shift   <= {w_data_synced, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_par_en) begin
                r_parity_ok <= ^{r_shift, w_data_synced};
            end
        end
    end

    // Stall detector: counts cycles since the last queda while a frame is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_queda || w_timeout || (r_state == StOcioso)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + ToW'(1);
        end
    end

    // Publish results: scancode one cycle after the stop bit, toggle one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scancode <= 8'h00;
            r_finish   <= 1'b0;
            r_erro     <= 1'b0;
            r_valid_d  <= 1'b0;
        end else begin
            r_erro    <= w_frame_err | w_timeout;
            r_valid_d <= w_frame_ok;
            if (w_frame_ok) begin
                r_scancode <= r_shift;
            end
            if (r_valid_d) begin
                r_finish <= ~r_finish;
            end
        end
    end

    assign ps2.scancode    = r_scancode;
    assign ps2.finish_ps2  = r_finish;
    assign ps2.erro_quadro = r_erro;

endmodule
